rob_param: RTL and testbench
============================

// Module: rob_param
// PURPOSE
//  Parametrised reorder buffer with DEPTH entries and NUM_WB completion ports; sits between fetch/decode and RS/LSB/CDB.
//  Allocates in-order tags, resolves LUI/JAL/AUIPC at dispatch, and collects out-of-order results.
//  Commits one entry per cycle in program order; a mispredict flush empties it in one cycle.
// PARAMETERS
//  DEPTH   16  entry count; power of two, >=4
//  TAG_W   4   tag width = log2(DEPTH)
//  NUM_WB  4   write-back channels (ALU1, ALU2, load, store by convention)
// PORTS
//  clk              in   1             clock
//  rst              in   1             reset: synchronous, active-high
//  rdy              in   1             global enable; low = freeze all state and outputs
//  disp_valid       in   1             decoded instruction offered
//  disp_ready       out  1             entry free (combinational: count != DEPTH)
//  disp_ins         in   32            instruction word
//  disp_pc          in   32            instruction PC
//  rs_valid         out  1             registered: instruction sent to RS
//  rs_ins           out  32            registered instruction word
//  rs_tag           out  TAG_W         allocated tag
//  rs_rd            out  5             destination register
//  ls_valid         out  1             registered: load/store allocated, in order, for LSB
//  ls_tag           out  TAG_W         load/store tag
//  wb_valid         in   NUM_WB        per-channel result strobe
//  wb_tag           in   NUM_WB*TAG_W  packed tags; channel i = [i*TAG_W +: TAG_W]
//  wb_data          in   NUM_WB*32     packed results
//  flush            in   1             mispredict flush
//  commit_valid     out  1             one-cycle commit pulse
//  commit_tag       out  TAG_W         committing tag
//  commit_rd        out  5             destination register
//  commit_value     out  32            result
//  commit_is_branch out  1             entry is BRANCH
//  commit_is_jalr   out  1             entry is JALR
//  commit_is_store  out  1             entry is STORE (rd ignored)
// BEHAVIOUR
//  - Reset: head = tail = count = 0; all entry valid/ready bits 0; every output 0.
//  - Priority in one cycle: rst > !rdy (hold) > flush > {writeback, commit, dispatch} in parallel.
//  - Dispatch fires when disp_valid && disp_ready. The entry at tail becomes valid and tail advances mod DEPTH.
//    - LUI/JAL/AUIPC: value = {imm,12'b0} / pc+4 / {imm,12'b0}+pc. Entry ready immediately. rs_valid and ls_valid stay 0.
//    - Any other opcode: entry not ready. rs_* is loaded and rs_valid=1 the next cycle.
//    - LOAD/STORE also set ls_valid=1 with ls_tag = tag.
//  - rs_valid and ls_valid drop to 0 in any cycle without a qualifying dispatch.
//  - Writeback: each set wb_valid[i] marks entry wb_tag[i] ready and stores wb_data[i].
//    - If two channels target the same tag in one cycle, the higher index wins.
//    - A strobe to an invalid entry is ignored.
//  - Commit: if count != 0 and head is valid and ready, then on the next edge:
//    - commit_valid=1 with the entry's fields; head advances; the entry is invalidated. Otherwise commit_valid=0.
//  - Latency: a writeback at edge E gives the head commit pulse after edge E+1. An immediate-type dispatch at E commits after E+1 at the earliest.
//  - count: +1 on dispatch, -1 on commit. It is unchanged when both happen together.
//    - When full, a commit in the same cycle does not free the slot for that cycle's dispatch; disp_ready stays 0.
//  - Wrap-around: head and tail wrap DEPTH-1 -> 0. full/empty come from count only, never from pointer compare.
//  - Flush: all entries invalid; head = tail = count = 0; all strobes 0.
//    - Dispatch, writeback and commit in the flush cycle are all discarded.
//  - rst mid-operation behaves exactly as flush and also clears the data outputs.
// CONFIGURATION
//  ROB_QUERY_EN defined:
//   - Adds two combinational operand-lookup ports: qry_tag[2] in, qry_ready[2] out, qry_value[2]*32 out.
//   - Each port returns the entry's ready bit and value.
//   - A same-cycle writeback to the queried tag is bypassed (ready=1, value=wb_data).
//  ROB_QUERY_EN undefined: the ports are absent and no bypass logic is built.
// STRUCTURE
//  - Package rob_pkg: opcode constants (LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH) and entry-state encoding.
//  - Sub-module rob_imm_calc: combinational (ins, pc) -> {is_imm_type, value}.
// TESTING
//  - Reset, then dispatch LUI x1,0x12345 at pc 0 -> rs_valid=0; next cycle commit_valid=1, rd=1, value=0x12345000.
//  - AUIPC x2,0x1 at pc 0x100 -> commit_value=0x1100. JAL x1 at pc 0x200 -> commit_value=0x204.
//  - Dispatch ADD(tag0), LW(tag1); wb tag1=0xAA, then tag0=5 -> commits in order: tag0/5, then tag1/0xAA; ls_valid pulses once with ls_tag=1.
//  - Fill 16 entries -> disp_ready=0; complete and commit head -> disp_ready=1 next cycle; dispatch wraps tail 15->0.
//  - wb ch0 and ch3 to tag 2 in the same cycle (0x11, 0x33) -> tag 2 commits with 0x33.
//  - Flush with 5 in flight plus dispatch and wb in the same cycle -> count=0, no commit_valid afterwards; the next dispatch gets tag 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared opcode constants, entry payload and decode helpers for the reorder buffer.
package rob_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // What the commit stage needs to know about an entry's instruction class.
    typedef enum logic [1:0] {
        KIND_OTHER  = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JALR   = 2'd2,
        KIND_STORE  = 2'd3
    } rob_kind_e;

    typedef struct packed {
        rob_kind_e        kind;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  value;
    } rob_entry_t;

    function automatic rob_kind_e kind_of(input logic [OPC_W-1:0] opc);
        rob_kind_e k;
        k = KIND_OTHER;
        if (opc == OPC_BRANCH) k = KIND_BRANCH;
        if (opc == OPC_JALR)   k = KIND_JALR;
        if (opc == OPC_STORE)  k = KIND_STORE;
        return k;
    endfunction

endpackage

// File: rtl/rob_imm_calc.sv
// Dispatch-time decode: resolves LUI/JAL/AUIPC results and classifies the instruction.
module rob_imm_calc
    import rob_pkg::*;
(
    input  logic [XLEN-1:0]  ins_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             is_imm_c,
    output logic             is_ls_c,
    output logic [REG_W-1:0] rd_c,
    output rob_kind_e        kind_c,
    output logic [XLEN-1:0]  value_c
);

    logic [OPC_W-1:0] opc;
    logic [XLEN-1:0]  upper;

    assign opc   = ins_i[OPC_W-1:0];
    assign upper = {ins_i[31:12], 12'h000};
    assign rd_c  = ins_i[11:7];
    assign kind_c = kind_of(opc);
    assign is_ls_c = (opc == OPC_LOAD) || (opc == OPC_STORE);

    always_comb begin
        is_imm_c = 1'b0;
        value_c  = '0;
        case (opc)
            OPC_LUI: begin
                is_imm_c = 1'b1;
                value_c  = upper;
            end
            OPC_JAL: begin
                is_imm_c = 1'b1;
                value_c  = pc_i + XLEN'(4);
            end
            OPC_AUIPC: begin
                is_imm_c = 1'b1;
                value_c  = upper + pc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/commit, out-of-order writeback, one-cycle flush.
// Optional operand lookup ports are built when ROB_QUERY_EN is defined.
module rob_param
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned NUM_WB = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [31:0]             disp_ins,
    input  logic [31:0]             disp_pc,
    output logic                    rs_valid,
    output logic [31:0]             rs_ins,
    output logic [TAG_W-1:0]        rs_tag,
    output logic [4:0]              rs_rd,
    output logic                    ls_valid,
    output logic [TAG_W-1:0]        ls_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*32-1:0]    wb_data,
    input  logic                    flush,
    output logic                    commit_valid,
    output logic [TAG_W-1:0]        commit_tag,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic                    commit_is_branch,
    output logic                    commit_is_jalr,
    output logic                    commit_is_store
`ifdef ROB_QUERY_EN
    ,
    input  logic [1:0][TAG_W-1:0]   qry_tag,
    output logic [1:0]              qry_ready,
    output logic [1:0][31:0]        qry_value
`endif
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
    rob_entry_t       entry_q [DEPTH];
    rob_entry_t       entry_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             rs_valid_q, rs_valid_d, ls_valid_q, ls_valid_d;
    logic [31:0]      rs_ins_q, rs_ins_d;
    logic [TAG_W-1:0] rs_tag_q, rs_tag_d, ls_tag_q, ls_tag_d;
    logic [4:0]       rs_rd_q, rs_rd_d;
    logic             cm_valid_q, cm_valid_d;
    logic [TAG_W-1:0] cm_tag_q, cm_tag_d;
    rob_entry_t       cm_entry_q, cm_entry_d;

    logic             dec_is_imm, dec_is_ls;
    logic [4:0]       dec_rd;
    rob_kind_e        dec_kind;
    logic [31:0]      dec_value;
    logic             do_commit, do_disp;

    rob_imm_calc u_imm_calc (
        .ins_i    (disp_ins),
        .pc_i     (disp_pc),
        .is_imm_c (dec_is_imm),
        .is_ls_c  (dec_is_ls),
        .rd_c     (dec_rd),
        .kind_c   (dec_kind),
        .value_c  (dec_value)
    );

    // Full/empty come from count alone; a same-cycle commit never frees the slot early.
    assign disp_ready = (count_q != CNT_W'(DEPTH));
    assign do_commit  = (count_q != '0) && valid_q[head_q] && ready_q[head_q];
    assign do_disp    = disp_valid && disp_ready;

    always_comb begin
        valid_d    = valid_q;
        ready_d    = ready_q;
        entry_d    = entry_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rs_valid_d = 1'b0;
        ls_valid_d = 1'b0;
        cm_valid_d = 1'b0;
        rs_ins_d   = rs_ins_q;
        rs_tag_d   = rs_tag_q;
        rs_rd_d    = rs_rd_q;
        ls_tag_d   = ls_tag_q;
        cm_tag_d   = cm_tag_q;
        cm_entry_d = cm_entry_q;

        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Ascending loop so the highest channel wins a same-tag collision.
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && valid_q[wb_tag[i*TAG_W +: TAG_W]]) begin
                    ready_d[wb_tag[i*TAG_W +: TAG_W]]       = 1'b1;
                    entry_d[wb_tag[i*TAG_W +: TAG_W]].value = wb_data[i*32 +: 32];
                end
            end

            if (do_commit) begin
                cm_valid_d      = 1'b1;
                cm_tag_d        = head_q;
                cm_entry_d      = entry_q[head_q];
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end

            if (do_disp) begin
                valid_d[tail_q]       = 1'b1;
                ready_d[tail_q]       = dec_is_imm;
                entry_d[tail_q].kind  = dec_kind;
                entry_d[tail_q].rd    = dec_rd;
                entry_d[tail_q].value = dec_value;
                tail_d                = tail_q + TAG_W'(1);
                if (!dec_is_imm) begin
                    rs_valid_d = 1'b1;
                    rs_ins_d   = disp_ins;
                    rs_tag_d   = tail_q;
                    rs_rd_d    = dec_rd;
                    if (dec_is_ls) begin
                        ls_valid_d = 1'b1;
                        ls_tag_d   = tail_q;
                    end
                end
            end

            count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            ready_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rs_valid_q <= 1'b0;
            rs_ins_q   <= '0;
            rs_tag_q   <= '0;
            rs_rd_q    <= '0;
            ls_valid_q <= 1'b0;
            ls_tag_q   <= '0;
            cm_valid_q <= 1'b0;
            cm_tag_q   <= '0;
            cm_entry_q <= '0;
        end else if (rdy) begin
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rs_valid_q <= rs_valid_d;
            rs_ins_q   <= rs_ins_d;
            rs_tag_q   <= rs_tag_d;
            rs_rd_q    <= rs_rd_d;
            ls_valid_q <= ls_valid_d;
            ls_tag_q   <= ls_tag_d;
            cm_valid_q <= cm_valid_d;
            cm_tag_q   <= cm_tag_d;
            cm_entry_q <= cm_entry_d;
        end
    end

    // Entry payload is qualified by valid/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            entry_q <= entry_d;
        end
    end

    assign rs_valid         = rs_valid_q;
    assign rs_ins           = rs_ins_q;
    assign rs_tag           = rs_tag_q;
    assign rs_rd            = rs_rd_q;
    assign ls_valid         = ls_valid_q;
    assign ls_tag           = ls_tag_q;
    assign commit_valid     = cm_valid_q;
    assign commit_tag       = cm_tag_q;
    assign commit_rd        = cm_entry_q.rd;
    assign commit_value     = cm_entry_q.value;
    assign commit_is_branch = (cm_entry_q.kind == KIND_BRANCH);
    assign commit_is_jalr   = (cm_entry_q.kind == KIND_JALR);
    assign commit_is_store  = (cm_entry_q.kind == KIND_STORE);

`ifdef ROB_QUERY_EN
    // Operand lookup with same-cycle writeback bypass.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            qry_ready[p] = ready_q[qry_tag[p]];
            qry_value[p] = entry_q[qry_tag[p]].value;
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && valid_q[qry_tag[p]] && (wb_tag[i*TAG_W +: TAG_W] == qry_tag[p])) begin
                    qry_ready[p] = 1'b1;
                    qry_value[p] = wb_data[i*32 +: 32];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios plus a randomized run against a queue-based model.
module tb_rob_param;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int NUM_WB = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;

    localparam logic [31:0] INS_ADD = {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_ALU};
    localparam logic [31:0] INS_LW  = {12'd0, 5'd1, 3'd2, 5'd4, OP_LOAD};

    logic                    clk = 1'b0;
    logic                    rst, rdy, disp_valid, disp_ready, flush;
    logic [31:0]             disp_ins, disp_pc;
    logic                    rs_valid, ls_valid, commit_valid;
    logic [31:0]             rs_ins, commit_value;
    logic [TAG_W-1:0]        rs_tag, ls_tag, commit_tag;
    logic [4:0]              rs_rd, commit_rd;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*32-1:0]    wb_data;
    logic                    commit_is_branch, commit_is_jalr, commit_is_store;

    always #5 clk = ~clk;

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ins(disp_ins), .disp_pc(disp_pc),
        .rs_valid(rs_valid), .rs_ins(rs_ins), .rs_tag(rs_tag), .rs_rd(rs_rd),
        .ls_valid(ls_valid), .ls_tag(ls_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_is_branch(commit_is_branch),
        .commit_is_jalr(commit_is_jalr), .commit_is_store(commit_is_store)
    );

    // Reference model: program-order queue of in-flight instructions, index 0 = oldest.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          done;
        logic [6:0]  op;
    } ent_t;

    ent_t        rob[$];
    int          next_tag;
    logic        e_rs_valid, e_ls_valid, e_cm_valid, e_cm_br, e_cm_jalr, e_cm_st;
    logic [31:0] e_rs_ins, e_cm_value;
    logic [3:0]  e_rs_tag, e_ls_tag, e_cm_tag;
    logic [4:0]  e_rs_rd, e_cm_rd;
    int          checks = 0;
    int          failures = 0;
    int          ls_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_outputs();
        e_rs_valid = 0; e_ls_valid = 0; e_cm_valid = 0;
        e_rs_ins = '0; e_rs_tag = '0; e_rs_rd = '0; e_ls_tag = '0;
        e_cm_tag = '0; e_cm_rd = '0; e_cm_value = '0;
        e_cm_br = 0; e_cm_jalr = 0; e_cm_st = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        ent_t        h;
        bit          do_c, do_d;
        logic [3:0]  t;
        logic [6:0]  op;
        ent_t        n;
        if (rst) begin
            rob.delete();
            next_tag = 0;
            model_clear_outputs();
        end else if (!rdy) begin
            // frozen
        end else if (flush) begin
            rob.delete();
            next_tag = 0;
            e_rs_valid = 0; e_ls_valid = 0; e_cm_valid = 0;
        end else begin
            do_c = (rob.size() > 0) && rob[0].done;
            do_d = disp_valid && (rob.size() < DEPTH);
            if (do_c) h = rob[0];
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i]) begin
                    t = wb_tag[i*TAG_W +: TAG_W];
                    foreach (rob[k]) begin
                        if (rob[k].tag == t) begin
                            rob[k].done = 1;
                            rob[k].val  = wb_data[i*32 +: 32];
                        end
                    end
                end
            end
            e_cm_valid = do_c;
            if (do_c) begin
                e_cm_tag   = h.tag;
                e_cm_rd    = h.rd;
                e_cm_value = h.val;
                e_cm_br    = (h.op == OP_BRANCH);
                e_cm_jalr  = (h.op == OP_JALR);
                e_cm_st    = (h.op == OP_STORE);
                void'(rob.pop_front());
            end
            e_rs_valid = 0;
            e_ls_valid = 0;
            if (do_d) begin
                op     = disp_ins[6:0];
                n.tag  = 4'(next_tag);
                n.rd   = disp_ins[11:7];
                n.op   = op;
                n.done = 1;
                n.val  = 32'd0;
                if (op == OP_LUI)        n.val = {disp_ins[31:12], 12'd0};
                else if (op == OP_JAL)   n.val = disp_pc + 32'd4;
                else if (op == OP_AUIPC) n.val = disp_pc + {disp_ins[31:12], 12'd0};
                else                     n.done = 0;
                if (!n.done) begin
                    e_rs_valid = 1;
                    e_rs_ins   = disp_ins;
                    e_rs_tag   = n.tag;
                    e_rs_rd    = n.rd;
                    if (op == OP_LOAD || op == OP_STORE) begin
                        e_ls_valid = 1;
                        e_ls_tag   = n.tag;
                    end
                end
                rob.push_back(n);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
    endtask

    task automatic tick();
        chk("disp_ready", 32'(disp_ready), 32'(rob.size() != DEPTH));
        model_edge();
        @(posedge clk);
        #1;
        if (ls_valid === 1'b1) ls_pulses++;
        chk("rs_valid", 32'(rs_valid), 32'(e_rs_valid));
        chk("rs_ins", rs_ins, e_rs_ins);
        chk("rs_tag", 32'(rs_tag), 32'(e_rs_tag));
        chk("rs_rd", 32'(rs_rd), 32'(e_rs_rd));
        chk("ls_valid", 32'(ls_valid), 32'(e_ls_valid));
        chk("ls_tag", 32'(ls_tag), 32'(e_ls_tag));
        chk("commit_valid", 32'(commit_valid), 32'(e_cm_valid));
        chk("commit_tag", 32'(commit_tag), 32'(e_cm_tag));
        chk("commit_rd", 32'(commit_rd), 32'(e_cm_rd));
        chk("commit_value", commit_value, e_cm_value);
        chk("commit_flags", 32'({commit_is_branch, commit_is_jalr, commit_is_store}),
            32'({e_cm_br, e_cm_jalr, e_cm_st}));
    endtask

    task automatic idle();
        disp_valid = 0; disp_ins = '0; disp_pc = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0;
        flush = 0; rdy = 1; rst = 0;
    endtask

    task automatic set_disp(input logic [31:0] ins, input logic [31:0] pc);
        disp_valid = 1; disp_ins = ins; disp_pc = pc;
    endtask

    task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] data);
        wb_valid[ch] = 1'b1;
        wb_tag[ch*TAG_W +: TAG_W] = tag;
        wb_data[ch*32 +: 32] = data;
    endtask

    logic [6:0] ops [9];
    logic [31:0] r;

    initial begin
        ops[0] = OP_LUI; ops[1] = OP_AUIPC; ops[2] = OP_JAL; ops[3] = OP_JALR; ops[4] = OP_BRANCH;
        ops[5] = OP_LOAD; ops[6] = OP_STORE; ops[7] = OP_ALU; ops[8] = OP_ALUI;
        ls_pulses = 0;
        idle();
        rst = 1;
        model_edge();
        @(posedge clk);
        #1;
        tick();
        chk("reset_commit_valid", 32'(commit_valid), 32'd0);
        chk("reset_disp_ready", 32'(disp_ready), 32'd1);
        idle();

        // Immediate-type dispatches resolve at dispatch and commit one cycle later.
        set_disp({20'h12345, 5'd1, OP_LUI}, 32'h0);
        tick();
        chk("lui_rs_valid", 32'(rs_valid), 32'd0);
        idle();
        tick();
        chk("lui_commit_valid", 32'(commit_valid), 32'd1);
        chk("lui_commit_rd", 32'(commit_rd), 32'd1);
        chk("lui_commit_value", commit_value, 32'h12345000);
        set_disp({20'h00001, 5'd2, OP_AUIPC}, 32'h100);
        tick();
        idle();
        tick();
        chk("auipc_value", commit_value, 32'h00001100);
        set_disp({20'h0, 5'd1, OP_JAL}, 32'h200);
        tick();
        idle();
        tick();
        chk("jal_value", commit_value, 32'h00000204);

        // Out-of-order writeback, in-order commit.
        flush = 1;
        tick();
        idle();
        ls_pulses = 0;
        set_disp(INS_ADD, 32'h300);
        tick();
        chk("add_rs_tag", 32'(rs_tag), 32'd0);
        set_disp(INS_LW, 32'h304);
        tick();
        chk("lw_ls_tag", 32'(ls_tag), 32'd1);
        idle();
        set_wb(0, 4'd1, 32'hAA);
        tick();
        idle();
        set_wb(1, 4'd0, 32'd5);
        tick();
        chk("ooo_no_early_commit", 32'(commit_valid), 32'd0);
        idle();
        tick();
        chk("ooo_first_tag", 32'(commit_tag), 32'd0);
        chk("ooo_first_value", commit_value, 32'd5);
        tick();
        chk("ooo_second_tag", 32'(commit_tag), 32'd1);
        chk("ooo_second_value", commit_value, 32'hAA);
        chk("ls_pulse_count", 32'(ls_pulses), 32'd1);

        // Fill to DEPTH, then free the head and wrap the tail.
        flush = 1;
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(INS_ADD, 32'(i * 4));
            tick();
        end
        idle();
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        set_wb(2, 4'd0, 32'd7);
        tick();
        idle();
        set_disp(INS_ADD, 32'h400);
        tick();
        chk("full_commit", 32'(commit_valid), 32'd1);
        chk("full_no_dispatch", 32'(rs_valid), 32'd0);
        chk("freed_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        chk("wrap_tag", 32'(rs_tag), 32'd0);
        idle();

        // Same-tag collision across channels: highest channel wins.
        flush = 1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_disp(INS_ADD, 32'h500);
            tick();
        end
        idle();
        set_wb(0, 4'd2, 32'h11);
        set_wb(1, 4'd0, 32'h1);
        set_wb(2, 4'd1, 32'h2);
        set_wb(3, 4'd2, 32'h33);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("collision_tag", 32'(commit_tag), 32'd2);
        chk("collision_value", commit_value, 32'h33);

        // Flush with traffic in the same cycle.
        for (int i = 0; i < 5; i++) begin
            set_disp(INS_ADD, 32'h600);
            tick();
        end
        idle();
        flush = 1;
        set_disp(INS_ADD, 32'h700);
        set_wb(0, 4'd3, 32'h99);
        tick();
        idle();
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_commit", 32'(commit_valid), 32'd0);
        end
        set_disp(INS_ADD, 32'h800);
        tick();
        chk("post_flush_tag", 32'(rs_tag), 32'd0);

        // rdy low freezes outputs.
        idle();
        rdy = 0;
        tick();
        chk("freeze_rs_valid", 32'(rs_valid), 32'd1);
        idle();
        tick();
        chk("unfreeze_rs_valid", 32'(rs_valid), 32'd0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle();
            if ($urandom_range(0, 2) != 0) begin
                r = $urandom();
                set_disp({r[31:7], ops[$urandom_range(0, 8)]}, $urandom() & 32'hFFFF_FFFC);
            end
            for (int ch = 0; ch < NUM_WB; ch++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                        set_wb(ch, rob[$urandom_range(0, rob.size() - 1)].tag, $urandom());
                    else
                        set_wb(ch, 4'($urandom()), $urandom());
                end
            end
            if ($urandom_range(0, 59) == 0) flush = 1;
            if ($urandom_range(0, 9) == 0) rdy = 0;
            if (cyc == 700) rst = 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
